multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- FSM sequencer for a multicycle RV32I datapath with a shared ALU, a single register-file write port and handshaked instruction/data memories.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives datapath enables, muxes and the ALU opcode each cycle.
- Traps on illegal opcodes and on memory handshake timeouts.

Parameters:
- TIMEOUT, 15: number of no-ready wait cycles tolerated on imem/dmem before trapping. Width of the wait counter is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction word from imem; valid when imem_ready=1
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch complete; ignored while imem_req=0
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; meaningful only when dmem_req=1
- dmem_ready  in  1  data access complete; ignored while dmem_req=0
- branch_taken  in  1  branch comparator result from the datapath
- ir_en  out  1  load the datapath instruction register
- pc_en  out  1  update PC
- pc_sel  out  2  PC source: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1
- reg_write  out  1  register-file write enable
- wb_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4
- alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate
- alu_control  out  5  ALU opcode, using the shared ALU encodings
- instr_retired  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky; high while in TRAP
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout

Behaviour:
- Reset (asynchronous): state=FETCH, wait_cnt=0, held instr=0, trap_cause=0, all outputs 0.
  - A reset asserted mid-operation drops imem_req/dmem_req immediately.
  - The first cycle after release is FETCH with imem_req=1.
- Outputs are combinational from state plus the registered instr. All outputs are 0 unless listed below.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_en=1, instr is latched internally, go to DECODE.
- DECODE:
  - Opcode not in {R, I-arith, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC} -> TRAP with cause 1.
  - Otherwise go to EXEC.
- EXEC: alu_control comes from the decoder. Per class:
  - R/I-arith/LUI/AUIPC: reg_write=1, wb_sel=0, pc_en=1, pc_sel=0, instr_retired=1, go to FETCH.
  - alu_src=0 for R and BRANCH; 1 for every other class.
  - BRANCH: alu_control=ALU_SUB, pc_en=1, pc_sel = branch_taken ? 1 : 0, instr_retired=1, go to FETCH.
  - JAL: reg_write=1, wb_sel=2, pc_en=1, pc_sel=1, retire, go to FETCH.
  - JALR: same as JAL with pc_sel=2.
  - LOAD/STORE: alu_control=ALU_ADD for the address, go to MEM.
- MEM:
  - dmem_req=1, dmem_we=1 for STORE, alu_src=1.
  - On dmem_ready: STORE -> pc_en=1, pc_sel=0, retire, go to FETCH. LOAD -> go to WB.
- WB: reg_write=1, wb_sel=1, pc_en=1, pc_sel=0, retire, go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH and MEM.
  - Increments each req cycle without ready.
  - If wait_cnt==TIMEOUT and ready=0 -> TRAP with cause 2 (FETCH) or 3 (MEM).
  - Ready in the same cycle as wait_cnt==TIMEOUT: ready wins.
  - The request is therefore held at most TIMEOUT+1 cycles.
- TRAP: trap=1 and trap_cause held. No pc_en, reg_write or requests. Exit only by rst.
- Latency with zero-wait memories: ALU/branch/jump 3 cycles, store 4, load 5.

Decomposition:
- Shared package holds:
  - opcode constants: OP_R=0110011, OP_I_ARITH=0010011, OP_I_LOAD=0000011, OP_S=0100011, OP_B=1100011, OP_J_JAL=1101111, OP_I_JALR=1100111, OP_U_LUI=0110111, OP_U_AUIPC=0010111
  - ALU_* 5-bit encodings
  - state enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}
  - pc_sel, wb_sel and trap_cause encodings
- One sub-module, alu_op_decoder: combinational map from the registered instr to alu_control.
  - R/I-arith decoded by func7/func3; LOAD/STORE/LUI/AUIPC/JALR -> ADD; BRANCH -> SUB; else NOP.

Test Plan:
- ADD x3,x1,x2: instr 0x002081B3 with imem_ready in the first cycle -> ir_en=1 at cycle 0. At cycle 2: alu_control=ALU_ADD, alu_src=0, reg_write=1, wb_sel=0, pc_en=1, pc_sel=0, instr_retired=1. imem_req=1 at cycle 3.
- LW: instr 0x0000A183, dmem_ready after 2 wait cycles -> dmem_req=1, dmem_we=0 for 3 cycles. WB cycle has reg_write=1, wb_sel=1, pc_en=1. 7 cycles total.
- SW 0x0020A023 -> dmem_we=1 and reg_write=0 throughout. BEQ 0x00208463 -> alu_control=ALU_SUB, reg_write=0, pc_sel=1 when branch_taken=1 and pc_sel=0 when branch_taken=0.
- Illegal opcode: instr 0x0000007F -> TRAP, trap=1, trap_cause=1. No pc_en or imem_req for 20 cycles. rst returns to FETCH with trap=0.
- imem_ready held 0, TIMEOUT=15 -> imem_req=1 for exactly 16 cycles, then trap_cause=2. Repeat with ready on the 16th cycle -> accepted, no trap.
- rst pulsed mid-MEM while dmem_req=1 -> dmem_req drops in the same cycle. After release: state=FETCH, imem_req=1, wait_cnt=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Purpose: shared opcode, ALU, state and mux-select encodings for the multicycle RV32I controller.
// Latency: n/a (constants, types and one pure helper function only).
// Backpressure: n/a.
package multicycle_controller_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I_ARITH = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_J_JAL   = 7'b1101111;
    localparam logic [6:0] OP_I_JALR  = 7'b1100111;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;

    // Shared ALU opcodes. NOP is zero so an idle controller drives an all-zero bus.
    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SLL  = 5'd3;
    localparam logic [4:0] ALU_SLT  = 5'd4;
    localparam logic [4:0] ALU_SLTU = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_OR   = 5'd9;
    localparam logic [4:0] ALU_AND  = 5'd10;

    // PC source select
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Trap causes
    localparam logic [1:0] TC_NONE    = 2'd0;
    localparam logic [1:0] TC_ILLEGAL = 2'd1;
    localparam logic [1:0] TC_IMEM    = 2'd2;
    localparam logic [1:0] TC_DMEM    = 2'd3;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        return (op == OP_R)      || (op == OP_I_ARITH) || (op == OP_I_LOAD) ||
               (op == OP_S)      || (op == OP_B)       || (op == OP_J_JAL)  ||
               (op == OP_I_JALR) || (op == OP_U_LUI)   || (op == OP_U_AUIPC);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// Purpose: maps the held instruction fields onto the shared ALU opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the registered instruction.
// Ports: opcode/funct3/funct7_b5 in (fields of the held instr), alu_control out (5-bit ALU opcode).
module alu_op_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [4:0] alu_control
);

    logic [4:0] arith_op;

    // funct3 -> operation, shared by R and I-arith. For I-arith, funct3=000 is
    // always ADDI (bit 30 is immediate data there), only shifts look at bit 30.
    always_comb begin
        arith_op = ALU_NOP;
        case (funct3)
            3'b000: arith_op = (funct7_b5 && opcode == OP_R) ? ALU_SUB : ALU_ADD;
            3'b001: arith_op = ALU_SLL;
            3'b010: arith_op = ALU_SLT;
            3'b011: arith_op = ALU_SLTU;
            3'b100: arith_op = ALU_XOR;
            3'b101: arith_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110: arith_op = ALU_OR;
            3'b111: arith_op = ALU_AND;
            default: arith_op = ALU_NOP;
        endcase
    end

    always_comb begin
        alu_control = ALU_NOP;
        case (opcode)
            OP_R, OP_I_ARITH:                            alu_control = arith_op;
            OP_I_LOAD, OP_S, OP_U_LUI, OP_U_AUIPC,
            OP_I_JALR:                                   alu_control = ALU_ADD;
            OP_B:                                        alu_control = ALU_SUB;
            default:                                     alu_control = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle RV32I datapath; traps on illegal opcode or memory timeout.
// Latency: zero-wait memories give 3 cycles for ALU/branch/jump, 4 for stores, 5 for loads.
// Backpressure: imem/dmem requests held until ready; TIMEOUT+1 request cycles without ready trap the core.
// Ports: clk/rst; instr, imem_req/imem_ready; dmem_req/dmem_we/dmem_ready; branch_taken;
//        datapath controls ir_en, pc_en, pc_sel, reg_write, wb_sel, alu_src, alu_control;
//        status instr_retired, trap, trap_cause.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic [4:0]  alu_control,
    output logic        instr_retired,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   WAIT_MAX = CW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]     instr_q, instr_d;
    logic [1:0]      trap_cause_q, trap_cause_d;

    logic [6:0]      opcode;
    logic [4:0]      dec_alu_control;
    logic            is_store;
    logic            unused_instr_bits;

    assign opcode   = instr_q[6:0];
    assign is_store = (opcode == OP_S);

    // Operand and immediate fields are consumed by the datapath's own IR copy.
    assign unused_instr_bits = ^{instr_q[31], instr_q[29:15], instr_q[11:7]};

    alu_op_decoder u_alu_op_decoder (
        .opcode      (opcode),
        .funct3      (instr_q[14:12]),
        .funct7_b5   (instr_q[30]),
        .alu_control (dec_alu_control)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            wait_cnt_q   <= '0;
            instr_q      <= '0;
            trap_cause_q <= TC_NONE;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            instr_q      <= instr_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        instr_d       = instr_q;
        trap_cause_d  = trap_cause_q;

        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_en         = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = PC_PLUS4;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        alu_src       = 1'b0;
        alu_control   = ALU_NOP;
        instr_retired = 1'b0;
        trap          = 1'b0;
        trap_cause    = trap_cause_q;

        // Gating on rst lets an asserted reset drop the memory requests within
        // the same cycle, not just after the flops settle into FETCH.
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_en   = 1'b1;
                        instr_d = instr;
                        state_d = DECODE;
                    end else if (wait_cnt_q == WAIT_MAX) begin
                        state_d      = TRAP;
                        trap_cause_d = TC_IMEM;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end

                DECODE: begin
                    if (is_legal_opcode(opcode)) begin
                        state_d = EXEC;
                    end else begin
                        state_d      = TRAP;
                        trap_cause_d = TC_ILLEGAL;
                    end
                end

                EXEC: begin
                    alu_control = dec_alu_control;
                    alu_src     = !((opcode == OP_R) || (opcode == OP_B));
                    case (opcode)
                        OP_R, OP_I_ARITH, OP_U_LUI, OP_U_AUIPC: begin
                            reg_write     = 1'b1;
                            wb_sel        = WB_ALU;
                            pc_en         = 1'b1;
                            pc_sel        = PC_PLUS4;
                            instr_retired = 1'b1;
                            state_d       = FETCH;
                            wait_cnt_d    = '0;
                        end
                        OP_B: begin
                            pc_en         = 1'b1;
                            pc_sel        = branch_taken ? PC_IMM : PC_PLUS4;
                            instr_retired = 1'b1;
                            state_d       = FETCH;
                            wait_cnt_d    = '0;
                        end
                        OP_J_JAL, OP_I_JALR: begin
                            reg_write     = 1'b1;
                            wb_sel        = WB_PC4;
                            pc_en         = 1'b1;
                            pc_sel        = (opcode == OP_J_JAL) ? PC_IMM : PC_JALR;
                            instr_retired = 1'b1;
                            state_d       = FETCH;
                            wait_cnt_d    = '0;
                        end
                        OP_I_LOAD, OP_S: begin
                            // Address is computed now; the ALU result is held by the datapath for MEM.
                            state_d    = MEM;
                            wait_cnt_d = '0;
                        end
                        default: begin
                            // Unreachable: DECODE already filtered the opcode.
                            state_d      = TRAP;
                            trap_cause_d = TC_ILLEGAL;
                        end
                    endcase
                end

                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    alu_src  = 1'b1;
                    if (dmem_ready) begin
                        if (is_store) begin
                            pc_en         = 1'b1;
                            pc_sel        = PC_PLUS4;
                            instr_retired = 1'b1;
                            state_d       = FETCH;
                            wait_cnt_d    = '0;
                        end else begin
                            state_d = WB;
                        end
                    end else if (wait_cnt_q == WAIT_MAX) begin
                        state_d      = TRAP;
                        trap_cause_d = TC_DMEM;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end

                WB: begin
                    reg_write     = 1'b1;
                    wb_sel        = WB_MEM;
                    pc_en         = 1'b1;
                    pc_sel        = PC_PLUS4;
                    instr_retired = 1'b1;
                    state_d       = FETCH;
                    wait_cnt_d    = '0;
                end

                TRAP: begin
                    trap = 1'b1;
                end

                default: begin
                    state_d    = FETCH;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

endmodule
